// File: rtl/spi_pkg.sv
// Shared SPI slave types: mode encoding, default synchroniser depth and
// the sample-edge decision used by the core.
package spi_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_t;

  localparam int SYNC_STAGES_DEF = 2;

  // Leading edge leaves the CPOL idle level; CPHA picks leading or trailing.
  function automatic logic is_sample_edge(input spi_mode_t mode,
                                          input logic rise,
                                          input logic fall);
    logic cpol;
    logic cpha;
    logic leading;
    logic trailing;
    {cpol, cpha} = mode;
    leading  = cpol ? fall : rise;
    trailing = cpol ? rise : fall;
    return cpha ? trailing : leading;
  endfunction

endpackage

// File: rtl/spi_slave_sync_in_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, followed by a
// history flop that yields single-cycle rise/fall strobes.
module spi_in_sync
  import spi_pkg::*;
#(
  parameter int   STAGES    = SYNC_STAGES_DEF,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
      hist  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      hist  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~hist;
  assign fall = ~sync & hist;

endmodule

// File: rtl/spi_slave_sync.sv
// System-clocked SPI slave, all four modes, streaming words per CS frame.
// Define SPI_SLAVE_RX_FIFO_EN to buffer received words in an RX FIFO.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic unused_sclk_lvl, unused_cs_lvl, unused_mosi_rise, unused_mosi_fall;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .sync(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(cs),
    .sync(unused_cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi),
    .sync(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  logic              active;
  spi_mode_t         mode_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_word;
  logic              sample_ev, shift_ev, word_done, load_ev;

  // With CPHA=0 the only shift edge seen at bit_cnt==0 is the one right after
  // a word's last sample, so one rule covers both phases once CS fall is added.
  always_comb begin
    sample_ev = active && is_sample_edge(mode_q, sclk_rise, sclk_fall);
    shift_ev  = active && (sclk_rise || sclk_fall) && !sample_ev;
    word_done = sample_ev && (bit_cnt == LAST_BIT);
    rx_word   = {rx_shift[DATA_W-2:0], mosi_s};
    load_ev   = (cs_fall && !cpha) || (shift_ev && (bit_cnt == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active      <= 1'b0;
      mode_q      <= MODE0;
      bit_cnt     <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_ready    <= load_ev;
      tx_underrun <= load_ev && !tx_valid;
      if (cs_rise) begin
        active   <= 1'b0;
        bit_cnt  <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
      end else begin
        if (cs_fall) begin
          active <= 1'b1;
          mode_q <= spi_mode_t'({cpol, cpha});
        end
        if (sample_ev) begin
          rx_shift <= rx_word;
          bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
        end
        if (load_ev)
          tx_shift <= tx_valid ? tx_data : '0;
        else if (shift_ev)
          tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign miso    = active & tx_shift[DATA_W-1];
  assign miso_oe = active;
  assign busy    = active;

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int PTR_W = $clog2(RX_FIFO_DEPTH);

  logic [DATA_W-1:0] fifo_mem [RX_FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full, pop, push;

  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    pop        = !fifo_empty && rx_ready;
    push       = word_done && (!fifo_full || pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= word_done && !push;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= rx_word;
  end

  assign rx_valid = !fifo_empty;
  assign rx_data  = fifo_empty ? '0 : fifo_mem[rd_ptr[PTR_W-1:0]];
`else
  localparam int unused_fifo_depth = RX_FIFO_DEPTH;

  logic              rx_valid_q;
  logic [DATA_W-1:0] rx_data_q;

  // A pop in the same cycle as completion frees the register for the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (word_done) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= rx_word;
          rx_valid_q <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// Self-checking bench for spi_slave_sync: an SPI master task drives frames,
// a feeder serves TX words on tx_ready, a monitor checks RX words against exp_q.
module tb_spi_slave_sync;
  import spi_pkg::*;

  localparam int DATA_W = 8;
  localparam int HALF   = 8;

  logic              clk, rst_n;
  logic              cpol, cpha, sclk, cs, mosi;
  logic              miso, miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid, tx_ready, tx_underrun;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, rx_ready, rx_overrun, busy;

  spi_slave_sync #(.DATA_W(DATA_W), .SYNC_STAGES(2), .RX_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha),
    .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_underrun(tx_underrun), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_overrun(rx_overrun), .busy(busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;
  int tx_loads = 0;
  int underruns = 0;
  int overruns = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W:0]   tx_src_q[$];
  logic [DATA_W-1:0] mo_w [8];
  logic [DATA_W-1:0] mi_w [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_ready)    tx_loads++;
      if (tx_underrun) underruns++;
      if (rx_overrun)  overruns++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected actual=0x%0h expected=none", rx_data);
        end else begin
          check("rx_word", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // TX driver: present next queued word after each handshake
  task automatic present_next();
    if (tx_src_q.size() > 0) begin
      {tx_valid, tx_data} = tx_src_q.pop_front();
    end else begin
      tx_valid = 1'b1;
      tx_data  = 8'hEE;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (tx_ready) begin
        @(posedge clk);
        #1;
        present_next();
      end
    end
  end

  // SPI master driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] wr, input int nbits, output logic [7:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = wr[7-i];
        wait_clk(HALF);
        rd[7-i] = miso;
        sclk = ~cpol;
        wait_clk(HALF);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = wr[7-i];
        wait_clk(HALF);
        rd[7-i] = miso;
        sclk = cpol;
        wait_clk(HALF);
      end
    end
  endtask

  task automatic frame_open(input logic [1:0] mode);
    cpol = mode[1];
    cpha = mode[0];
    sclk = mode[1];
    wait_clk(HALF);
    cs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic run_frame(input logic [1:0] mode, input int nwords, input int last_bits);
    frame_open(mode);
    for (int w = 0; w < nwords; w++)
      spi_bits(mo_w[w], (w == nwords - 1) ? last_bits : 8, mi_w[w]);
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic clear_counts();
    tx_loads  = 0;
    underruns = 0;
    overruns  = 0;
  endtask

  // CPHA=0 also loads on the final trailing edge, priming a word that CS rise discards.
  function automatic int loads_for(input logic [1:0] mode, input int nwords);
    return nwords + (mode[0] ? 0 : 1);
  endfunction

  task automatic check_outputs_zero(input string name);
    check({name, "_ctl"}, 32'({miso, miso_oe, tx_ready, tx_underrun, rx_valid, rx_overrun, busy}), 32'h0);
    check({name, "_rx_data"}, 32'(rx_data), 32'h0);
  endtask

  logic [7:0] junk;

  initial begin
    rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b1;
    wait_clk(3);
    check_outputs_zero("reset");
    check("reset_bit_cnt", 32'(dut.bit_cnt), 32'h0);
    rst_n = 1'b1;
    wait_clk(4);

    // single word in each mode: master reads 0xA5, slave receives 0x3C
    for (int m = 0; m < 4; m++) begin
      tx_src_q.push_back({1'b1, 8'hA5});
      present_next();
      exp_q.push_back(8'h3C);
      mo_w[0] = 8'h3C;
      clear_counts();
      run_frame(2'(m), 1, 8);
      check($sformatf("m%0d_miso_word", m), 32'(mi_w[0]), 32'hA5);
      check($sformatf("m%0d_tx_loads", m), 32'(tx_loads), 32'(loads_for(2'(m), 1)));
      check($sformatf("m%0d_underruns", m), 32'(underruns), 32'h0);
      check($sformatf("m%0d_rx_drained", m), 32'(exp_q.size()), 32'h0);
    end

    // back-to-back words, modes 0 and 3
    for (int k = 0; k < 2; k++) begin
      logic [1:0] mode;
      mode = (k == 0) ? 2'd0 : 2'd3;
      tx_src_q.push_back({1'b1, 8'hA1});
      tx_src_q.push_back({1'b1, 8'hB2});
      tx_src_q.push_back({1'b1, 8'hC3});
      present_next();
      mo_w[0] = 8'h11; mo_w[1] = 8'h22; mo_w[2] = 8'h33;
      exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
      clear_counts();
      run_frame(mode, 3, 8);
      check($sformatf("b2b_m%0d_w0", mode), 32'(mi_w[0]), 32'hA1);
      check($sformatf("b2b_m%0d_w1", mode), 32'(mi_w[1]), 32'hB2);
      check($sformatf("b2b_m%0d_w2", mode), 32'(mi_w[2]), 32'hC3);
      check($sformatf("b2b_m%0d_loads", mode), 32'(tx_loads), 32'(loads_for(mode, 3)));
      check($sformatf("b2b_m%0d_rx_drained", mode), 32'(exp_q.size()), 32'h0);
    end

    // underrun on word 2
    tx_src_q.push_back({1'b1, 8'h5A});
    tx_src_q.push_back({1'b0, 8'hFF});
    tx_src_q.push_back({1'b1, 8'hC3});
    present_next();
    mo_w[0] = 8'h01; mo_w[1] = 8'h80; mo_w[2] = 8'h7E;
    exp_q.push_back(8'h01); exp_q.push_back(8'h80); exp_q.push_back(8'h7E);
    clear_counts();
    run_frame(2'd0, 3, 8);
    check("udr_w0", 32'(mi_w[0]), 32'h5A);
    check("udr_w1", 32'(mi_w[1]), 32'h00);
    check("udr_w2", 32'(mi_w[2]), 32'hC3);
    check("udr_count", 32'(underruns), 32'h1);

    // CS abort after 5 bits in mode 1, then a clean frame
    tx_src_q.push_back({1'b1, 8'h96});
    present_next();
    mo_w[0] = 8'hF0;
    clear_counts();
    run_frame(2'd1, 1, 5);
    check("abort_rx_valid", 32'(rx_valid), 32'h0);
    check("abort_bit_cnt", 32'(dut.bit_cnt), 32'h0);
    check("abort_miso_oe", 32'(miso_oe), 32'h0);
    check("abort_loads", 32'(tx_loads), 32'h1);
    tx_src_q.push_back({1'b1, 8'h69});
    present_next();
    mo_w[0] = 8'h81;
    exp_q.push_back(8'h81);
    run_frame(2'd1, 1, 8);
    check("post_abort_miso", 32'(mi_w[0]), 32'h69);

    // overrun with rx_ready held low
    rx_ready = 1'b0;
    present_next();
    mo_w[0] = 8'h10; mo_w[1] = 8'h20; mo_w[2] = 8'h30; mo_w[3] = 8'h40; mo_w[4] = 8'h50;
    clear_counts();
`ifdef SPI_SLAVE_RX_FIFO_EN
    for (int i = 0; i < 4; i++) exp_q.push_back(mo_w[i]);
    run_frame(2'd0, 5, 8);
`else
    exp_q.push_back(8'h10);
    run_frame(2'd0, 2, 8);
`endif
    check("ovr_count", 32'(overruns), 32'h1);
    check("ovr_rx_valid", 32'(rx_valid), 32'h1);
    check("ovr_rx_data", 32'(rx_data), 32'h10);
    rx_ready = 1'b1;
    wait_clk(8);
    check("ovr_rx_drained", 32'(exp_q.size()), 32'h0);

    // reset mid-frame in mode 2, then a fresh frame
    tx_src_q.push_back({1'b1, 8'h77});
    present_next();
    frame_open(2'd2);
    spi_bits(8'hFF, 3, junk);
    #1 rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    cs = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(HALF);
    tx_src_q.push_back({1'b1, 8'h3C});
    present_next();
    mo_w[0] = 8'hA5;
    exp_q.push_back(8'hA5);
    clear_counts();
    run_frame(2'd2, 1, 8);
    check("post_rst_miso", 32'(mi_w[0]), 32'h3C);
    check("post_rst_loads", 32'(tx_loads), 32'(loads_for(2'd2, 1)));
    check("post_rst_rx_drained", 32'(exp_q.size()), 32'h0);

    wait_clk(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
